// File: rtl/audio_mix_sequencer_if.sv
// Stereo mixer port bundle: sample sources and strobe in, mixed stereo word out.
// The mixer connects through the slave modport; the source side uses master.
interface audio_mix_sequencer_if #(
   parameter int unsigned NUM_SOURCES  = 4,
   parameter int unsigned SAMPLE_WIDTH = 16
);
   logic                                  sample_strobe_i;
   logic [NUM_SOURCES*SAMPLE_WIDTH-1:0]   src_l_i;
   logic [NUM_SOURCES*SAMPLE_WIDTH-1:0]   src_r_i;
   logic [NUM_SOURCES-1:0]                src_en_i;
   logic [2*NUM_SOURCES-1:0]              src_att_i;
   logic [SAMPLE_WIDTH-1:0]               sample_l_o;
   logic [SAMPLE_WIDTH-1:0]               sample_r_o;
   logic                                  sample_valid_o;
   logic                                  clip_l_o;
   logic                                  clip_r_o;
   logic                                  busy_o;
   logic [7:0]                            overrun_count_o;

   modport master (
      output sample_strobe_i, src_l_i, src_r_i, src_en_i, src_att_i,
      input  sample_l_o, sample_r_o, sample_valid_o, clip_l_o, clip_r_o, busy_o,
             overrun_count_o
   );

   modport slave (
      input  sample_strobe_i, src_l_i, src_r_i, src_en_i, src_att_i,
      output sample_l_o, sample_r_o, sample_valid_o, clip_l_o, clip_r_o, busy_o,
             overrun_count_o
   );
endinterface

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed stereo mixer: snapshots all sources on the audio strobe, sums them
// through one shared adder (L/R interleaved), saturates to SAMPLE_WIDTH and pulses valid.
module audio_mix_sequencer #(
   parameter int unsigned NUM_SOURCES  = 4,
   parameter int unsigned SAMPLE_WIDTH = 16
) (
   input logic                  clk_pixel,
   input logic                  reset,
   audio_mix_sequencer_if.slave bus
);
   localparam int unsigned N     = NUM_SOURCES;
   localparam int unsigned W     = SAMPLE_WIDTH;
   localparam int unsigned ACC_W = W + $clog2(N) + 1;
   localparam int unsigned SW    = $clog2(2 * N);
   localparam logic [SW-1:0] LAST_STEP = SW'(2 * N - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAcc, StSat} state_e;

   state_e                  r_state, w_state_next;
   logic [N*W-1:0]          r_snap_l, r_snap_r;
   logic [N-1:0]            r_snap_en;
   logic [2*N-1:0]          r_snap_att;
   logic [SW-1:0]           r_step;
   logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
   logic [W-1:0]            r_sample_l, r_sample_r;
   logic                    r_clip_l, r_clip_r, r_valid;
   logic [7:0]              r_overrun;

   logic [SW-2:0]           w_src;
   logic                    w_is_r;
   logic [W-1:0]            w_sample;
   logic [1:0]              w_att;
   logic                    w_en;
   logic signed [ACC_W-1:0] w_ext, w_shift, w_operand, w_acc_sel, w_sum;
   logic [W-1:0]            w_word_l, w_word_r;
   logic                    w_clip_l, w_clip_r;

   // Shared operand mux and adder; even steps feed left, odd steps feed right.
   always_comb begin
      w_src     = r_step[SW-1:1];
      w_is_r    = r_step[0];
      w_sample  = w_is_r ? r_snap_r[w_src*W +: W] : r_snap_l[w_src*W +: W];
      w_att     = r_snap_att[w_src*2 +: 2];
      w_en      = r_snap_en[w_src];
      w_ext     = {{(ACC_W-W){w_sample[W-1]}}, w_sample};
      // Kept separate from the enable mux so the shift stays arithmetic.
      w_shift   = w_ext >>> w_att;
      w_operand = w_en ? w_shift : '0;
      w_acc_sel = w_is_r ? r_acc_r : r_acc_l;
      w_sum     = w_acc_sel + w_operand;
   end

   always_comb begin
      w_word_l = r_acc_l[W-1:0];
      w_clip_l = 1'b0;
      if (r_acc_l > SAT_MAX) begin
         w_word_l = SAT_MAX[W-1:0];
         w_clip_l = 1'b1;
      end else if (r_acc_l < SAT_MIN) begin
         w_word_l = SAT_MIN[W-1:0];
         w_clip_l = 1'b1;
      end
      w_word_r = r_acc_r[W-1:0];
      w_clip_r = 1'b0;
      if (r_acc_r > SAT_MAX) begin
         w_word_r = SAT_MAX[W-1:0];
         w_clip_r = 1'b1;
      end else if (r_acc_r < SAT_MIN) begin
         w_word_r = SAT_MIN[W-1:0];
         w_clip_r = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (bus.sample_strobe_i) w_state_next = StAcc;
         StAcc:   if (r_step == LAST_STEP) w_state_next = StSat;
         StSat:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         r_snap_l   <= '0;
         r_snap_r   <= '0;
         r_snap_en  <= '0;
         r_snap_att <= '0;
         r_step     <= '0;
         r_acc_l    <= '0;
         r_acc_r    <= '0;
         r_sample_l <= '0;
         r_sample_r <= '0;
         r_clip_l   <= 1'b0;
         r_clip_r   <= 1'b0;
         r_valid    <= 1'b0;
         r_overrun  <= '0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (bus.sample_strobe_i) begin
                  r_snap_l   <= bus.src_l_i;
                  r_snap_r   <= bus.src_r_i;
                  r_snap_en  <= bus.src_en_i;
                  r_snap_att <= bus.src_att_i;
                  r_acc_l    <= '0;
                  r_acc_r    <= '0;
                  r_step     <= '0;
               end
            end
            StAcc: begin
               if (w_is_r) r_acc_r <= w_sum;
               else        r_acc_l <= w_sum;
               r_step <= r_step + 1'b1;
            end
            StSat: begin
               r_sample_l <= w_word_l;
               r_sample_r <= w_word_r;
               r_clip_l   <= w_clip_l;
               r_clip_r   <= w_clip_r;
               r_valid    <= 1'b1;
            end
            default: ;
         endcase
         if (bus.sample_strobe_i && r_state != StIdle && r_overrun != 8'hFF) begin
            r_overrun <= r_overrun + 8'd1;
         end
      end
   end

   assign bus.sample_l_o      = r_sample_l;
   assign bus.sample_r_o      = r_sample_r;
   assign bus.sample_valid_o  = r_valid;
   assign bus.clip_l_o        = r_clip_l;
   assign bus.clip_r_o        = r_clip_r;
   assign bus.busy_o          = (r_state != StIdle);
   assign bus.overrun_count_o = r_overrun;
endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Directed bench for audio_mix_sequencer (N=4, W=16): mix, latency, saturation,
// attenuation, overrun, back-to-back strobes, snapshot isolation and mid-word reset.
module tb_audio_mix_sequencer;
   logic clk_pixel = 1'b0;
   logic reset     = 1'b1;
   int   checks    = 0;
   int   failures  = 0;

   audio_mix_sequencer_if #(.NUM_SOURCES(4), .SAMPLE_WIDTH(16)) bus ();

   audio_mix_sequencer #(.NUM_SOURCES(4), .SAMPLE_WIDTH(16)) dut (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .bus       (bus.slave)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Pulse the strobe, then wait (bounded) for valid; returns cycles from strobe edge.
   task automatic run_word(output int lat);
      bus.sample_strobe_i = 1'b1;
      tick();
      bus.sample_strobe_i = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.sample_valid_o) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic set_src(input logic [63:0] l, input logic [63:0] r,
                          input logic [3:0] en, input logic [7:0] att);
      bus.src_l_i   = l;
      bus.src_r_i   = r;
      bus.src_en_i  = en;
      bus.src_att_i = att;
   endtask

   initial begin
      int lat;
      int nv;
      bus.sample_strobe_i = 1'b0;
      set_src('0, '0, '0, '0);

      repeat (3) tick();
      check("reset_l", bus.sample_l_o, 16'h0000);
      check("reset_r", bus.sample_r_o, 16'h0000);
      check("reset_flags", {bus.sample_valid_o, bus.clip_l_o, bus.clip_r_o, bus.busy_o}, 4'b0);
      check("reset_ovr", bus.overrun_count_o, 8'd0);
      reset = 1'b0;
      tick();

      // Basic mix: L 100+200, R -50+50, sources 2/3 disabled
      set_src({16'h7FFF, 16'h7FFF, 16'd200, 16'd100},
              {16'h7FFF, 16'h7FFF, 16'd50, 16'hFFCE}, 4'b0011, 8'h00);
      run_word(lat);
      check("basic_lat", lat, 9);
      check("basic_l", bus.sample_l_o, 16'h012C);
      check("basic_r", bus.sample_r_o, 16'h0000);
      check("basic_clip", {bus.clip_l_o, bus.clip_r_o}, 2'b00);
      check("basic_busy_valid", bus.busy_o, 1'b0);
      tick();
      check("basic_single_pulse", bus.sample_valid_o, 1'b0);
      check("basic_hold_l", bus.sample_l_o, 16'h012C);

      // Saturation both directions
      set_src({4{16'h7000}}, {4{16'h9000}}, 4'hF, 8'h00);
      run_word(lat);
      check("sat_lat", lat, 9);
      check("sat_l", bus.sample_l_o, 16'h7FFF);
      check("sat_r", bus.sample_r_o, 16'h8000);
      check("sat_clip", {bus.clip_l_o, bus.clip_r_o}, 2'b11);
      tick();

      // Attenuation: 0x1000>>>2 + 0xF000>>>3 = 0x0400 + 0xFE00
      set_src({16'h7FFF, 16'h7FFF, 16'hF000, 16'h1000}, '0, 4'b0011, 8'h0E);
      run_word(lat);
      check("att_l", bus.sample_l_o, 16'h0200);
      check("att_r", bus.sample_r_o, 16'h0000);
      check("att_clip", {bus.clip_l_o, bus.clip_r_o}, 2'b00);
      tick();

      // Overrun: second strobe at k+3 is dropped
      set_src({16'h7FFF, 16'h7FFF, 16'd200, 16'd100},
              {16'h7FFF, 16'h7FFF, 16'd50, 16'hFFCE}, 4'b0011, 8'h00);
      bus.sample_strobe_i = 1'b1;
      tick();
      bus.sample_strobe_i = 1'b0;
      check("ovr_busy", bus.busy_o, 1'b1);
      tick();
      tick();
      bus.sample_strobe_i = 1'b1;
      tick();
      bus.sample_strobe_i = 1'b0;
      nv  = 0;
      lat = 0;
      for (int i = 4; i <= 14; i++) begin
         tick();
         if (bus.sample_valid_o) begin
            nv++;
            if (lat == 0) lat = i;
         end
      end
      check("ovr_valids", nv, 1);
      check("ovr_lat", lat, 9);
      check("ovr_count", bus.overrun_count_o, 8'd1);

      // Back-to-back: strobe in the valid cycle is accepted
      set_src({4{16'h7000}}, {4{16'h9000}}, 4'hF, 8'h00);
      run_word(lat);
      check("b2b_first_lat", lat, 9);
      set_src({16'h7FFF, 16'h7FFF, 16'hF000, 16'h1000}, '0, 4'b0011, 8'h0E);
      run_word(lat);
      check("b2b_second_lat", lat, 9);
      check("b2b_l", bus.sample_l_o, 16'h0200);
      check("b2b_ovr", bus.overrun_count_o, 8'd1);
      tick();

      // Snapshot isolation: inputs change after edge k+2
      set_src({16'h7FFF, 16'h7FFF, 16'd200, 16'd100},
              {16'h7FFF, 16'h7FFF, 16'd50, 16'hFFCE}, 4'b0011, 8'h00);
      bus.sample_strobe_i = 1'b1;
      tick();
      bus.sample_strobe_i = 1'b0;
      tick();
      tick();
      set_src({4{16'h7000}}, {4{16'h9000}}, 4'hF, 8'hFF);
      lat = 0;
      for (int i = 3; i <= 20; i++) begin
         tick();
         if (bus.sample_valid_o) begin
            lat = i;
            break;
         end
      end
      check("snap_lat", lat, 9);
      check("snap_l", bus.sample_l_o, 16'h012C);
      check("snap_r", bus.sample_r_o, 16'h0000);
      tick();

      // Continuous strobe: drops far exceed 255, counter saturates
      bus.sample_strobe_i = 1'b1;
      repeat (400) tick();
      bus.sample_strobe_i = 1'b0;
      repeat (12) tick();
      check("ovr_saturate", bus.overrun_count_o, 8'd255);

      // Reset at k+4 aborts the word
      set_src({4{16'h7000}}, {4{16'h9000}}, 4'hF, 8'h00);
      bus.sample_strobe_i = 1'b1;
      tick();
      bus.sample_strobe_i = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check("rst_l", bus.sample_l_o, 16'h0000);
      check("rst_r", bus.sample_r_o, 16'h0000);
      check("rst_flags", {bus.sample_valid_o, bus.clip_l_o, bus.clip_r_o, bus.busy_o}, 4'b0);
      check("rst_ovr", bus.overrun_count_o, 8'd0);
      repeat (2) tick();
      reset = 1'b0;
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.sample_valid_o) nv++;
      end
      check("rst_no_valid", nv, 0);

      // First word after reset
      run_word(lat);
      check("post_rst_lat", lat, 9);
      check("post_rst_l", bus.sample_l_o, 16'h7FFF);
      check("post_rst_r", bus.sample_r_o, 16'h8000);
      check("post_rst_clip", {bus.clip_l_o, bus.clip_r_o}, 2'b11);
      check("post_rst_ovr", bus.overrun_count_o, 8'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/audio_mix_sequencer.md
# audio_mix_sequencer

Time-multiplexed audio mixer and sample scheduler for the HDMI audio path. On each audio-rate strobe it snapshots up to NUM_SOURCES stereo sample inputs, such as SuperSprite PSG, Mockingboard L/R and the speaker pulse. It accumulates them through a single shared adder with per-source enable and attenuation, saturates the result to 16-bit signed, and presents one registered stereo word with a valid pulse to the HDMI encoder. It runs entirely in the pixel clock domain; the strobe is the existing audio-rate tick.

## Interface
Parameters:
- NUM_SOURCES, 4: number of stereo sources; legal range 2..8.
- SAMPLE_WIDTH, 16: width of each source sample and of the output, in two's complement.

Ports:
- clk_pixel  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_strobe_i  in  1  single-cycle audio-rate tick.
- src_l_i  in  NUM_SOURCES*SAMPLE_WIDTH  left samples, signed; source n occupies bits [n*W +: W].
- src_r_i  in  NUM_SOURCES*SAMPLE_WIDTH  right samples, same packing.
- src_en_i  in  NUM_SOURCES  per-source enable; 0 contributes zero.
- src_att_i  in  2*NUM_SOURCES  per-source arithmetic right shift 0..3; source n uses bits [2n +: 2].
- sample_l_o  out  SAMPLE_WIDTH  mixed left word.
- sample_r_o  out  SAMPLE_WIDTH  mixed right word.
- sample_valid_o  out  1  one-cycle pulse; the sample words are new that cycle.
- clip_l_o, clip_r_o  out  1  saturation occurred in the current word; updated together with the sample words.
- busy_o  out  1  high whenever the state is not IDLE.
- overrun_count_o  out  8  count of dropped strobes; saturates at 255.

## Operation
- States: IDLE, ACC, SAT.
- IDLE behaviour on sample_strobe_i:
  - Register snapshots of src_l_i, src_r_i, src_en_i and src_att_i.
  - Clear acc to 0 and the step counter s to 0.
  - Go to ACC.
- ACC, one add per cycle, step s = 0..2N-1:
  - Channel is L if s[0]=0, R if s[0]=1.
  - Source index is s>>1.
  - Operand is the sign-extended snapshot sample, arithmetic-right-shifted by its att value, forced to 0 if its en bit is 0.
  - Even steps add into acc_l, odd steps into acc_r. Both share the single adder and operand mux.
  - At s = 2N-1, go to SAT.
- Accumulator width is SAMPLE_WIDTH + clog2(NUM_SOURCES) + 1, signed. No intermediate overflow is possible.
- SAT, one cycle:
  - For each channel, if acc > 2^(W-1)-1, output 2^(W-1)-1 and set clip.
  - If acc < -2^(W-1), output -2^(W-1) and set clip.
  - Otherwise output acc[W-1:0] and clear clip.
  - Register the sample words and clip flags, pulse sample_valid_o, and return to IDLE.
- A strobe arriving while state ≠ IDLE is dropped and overrun_count_o increments. The in-flight computation is unaffected.
- Input changes after the snapshot have no effect on the word being computed.
- Outputs hold their last value between valid pulses.

## Timing
- Reset values: sample_l_o=0, sample_r_o=0, sample_valid_o=0, clip_l_o=0, clip_r_o=0, busy_o=0, overrun_count_o=0. State is IDLE; acc and the snapshots are 0.
- Reset asserted mid-ACC or mid-SAT aborts immediately; no valid pulse is produced. The first strobe after reset release is accepted normally.
- Latency: the strobe is sampled at edge k.
  - ACC adds occur at edges k+1..k+2N.
  - SAT registers the outputs at edge k+2N+1.
  - sample_valid_o is high for exactly the cycle following edge k+2N+1.
  - With N=4, the latency is 9 cycles.
- busy_o is high from the cycle after edge k through the cycle after edge k+2N, and low in the valid cycle.
- A strobe present in the valid cycle is accepted, because the state is already IDLE. The minimum strobe spacing is therefore 2N+2 cycles.
- sample_valid_o is never asserted for two consecutive cycles.

## Test plan
- Basic mix and latency: N=4, en=4'b0011, att=0, L={100,200,x,x}, R={-50,50,x,x}, strobe at edge k -> sample_l_o=300, sample_r_o=0, clip=0, valid only in the cycle after edge k+9.
- Saturation, positive: all 4 L sources = 16'h7000, en=4'hF -> sample_l_o=16'h7FFF, clip_l_o=1.
- Saturation, negative: all 4 R sources = 16'h9000 -> sample_r_o=16'h8000, clip_r_o=1.
- Attenuation: src0 L=16'h1000 with att=2, src1 L=-16'h1000 (16'hF000) with att=3, others disabled -> sample_l_o=16'h0400+16'hFE00=16'h0200. Arithmetic shift is confirmed.
- Overrun and back-to-back:
  - Strobe at edge k and a second strobe at k+3 -> one valid only, overrun_count_o=1.
  - A strobe in the valid cycle -> accepted, second valid 9 cycles later.
  - 300 dropped strobes -> counter holds at 255.
- Snapshot isolation and reset:
  - Change src inputs at k+2 -> result reflects the k-edge values.
  - Assert reset at k+4 -> all outputs 0, no valid pulse.
  - After release, a strobe yields a correct word.
